// File: rtl/serial_add_sub.sv
// Digit-serial WIDTH-bit adder/subtracter: one 4-bit nibble per clock, LSB nibble first,
// with the inter-nibble carry held in a register and valid/ready handshakes on both sides.
module serial_add_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_ci;
    logic             r_sub;
    logic             r_carry;
    logic             r_co;
    logic             r_ov;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_lastNib;
    logic [3:0]       w_aNib;
    logic [3:0]       w_bNib;
    logic             w_cin;
    logic [4:0]       w_sum;

    assign in_ready  = rst_n && (r_state == IDLE);
    assign w_accept  = in_valid && in_ready;
    assign w_lastNib = (r_cnt == CW'(N - 1));
    assign out_valid = (r_state == DONE);
    assign s         = r_s;
    assign co        = r_co;
    assign ov        = r_ov;

    // Single 4-bit slice; subtraction inverts b and the nibble-0 carry-in.
    always_comb begin
        w_aNib = r_a[{r_cnt, 2'b00} +: 4];
        w_bNib = r_b[{r_cnt, 2'b00} +: 4] ^ {4{r_sub}};
        w_cin  = (r_cnt == '0) ? (r_ci ^ r_sub) : r_carry;
        w_sum  = {1'b0, w_aNib} + {1'b0, w_bNib} + {4'b0000, w_cin};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (w_lastNib) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture and per-nibble result/carry accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ci    <= 1'b0;
            r_sub   <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_ci  <= ci;
                        r_sub <= sub;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_s[{r_cnt, 2'b00} +: 4] <= w_sum[3:0];
                    r_carry                  <= w_sum[4];
                    if (w_lastNib) begin
                        r_co <= w_sum[4];
                        r_ov <= (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_sub)) &&
                                (w_sum[3] != r_a[WIDTH-1]);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
